// File: rtl/battleship_pkg.sv
// Shared types and probe-walk helpers for the battleship turn controller.
package battleship_pkg;
   typedef logic [3:0] coord_t;
   typedef logic [4:0] ship_t;

   localparam int         GRID_MAX_C = 10;
   localparam logic [3:0] NO_PROBE   = 4'd9;

   typedef enum logic [1:0] {IDLE, CHECK, SCAN, REPORT} seq_state_t;

   // Probe index k walks the 3x3 block row-major: dx = k%3 - 1, dy = k/3 - 1.
   function automatic logic [1:0] idx_dx(input logic [3:0] k);
      case (k)
         4'd0, 4'd3, 4'd6: return 2'd0;
         4'd1, 4'd4, 4'd7: return 2'd1;
         default:          return 2'd2;
      endcase
   endfunction

   function automatic logic [1:0] idx_dy(input logic [3:0] k);
      if (k < 4'd3)      return 2'd0;
      else if (k < 4'd6) return 2'd1;
      else               return 2'd2;
   endfunction

   function automatic logic [4:0] offset_coord(input coord_t c, input logic [1:0] off);
      return {1'b0, c} + {3'b000, off} - 5'd1;
   endfunction

   function automatic logic in_grid(input logic [4:0] c, input int gmax);
      return (c != 5'd0) && (int'(c) <= gmax);
   endfunction

   function automatic logic probe_ok(input coord_t cx, input coord_t cy, input logic big,
                                     input logic [3:0] k, input int gmax);
      if (big) return in_grid(offset_coord(cx, idx_dx(k)), gmax) &&
                      in_grid(offset_coord(cy, idx_dy(k)), gmax);
      else     return k == 4'd4;
   endfunction

   // Lowest legal probe index >= start, or NO_PROBE when the footprint is exhausted.
   function automatic logic [3:0] next_probe(input coord_t cx, input coord_t cy, input logic big,
                                             input logic [3:0] start, input int gmax);
      logic [3:0] res;
      res = NO_PROBE;
      for (int k = 8; k >= 0; k--) begin
         if (4'(k) >= start && probe_ok(cx, cy, big, 4'(k), gmax)) res = 4'(k);
      end
      return res;
   endfunction
endpackage

// File: rtl/score_sync.sv
// Two-flop synchronizer for the active-low score key plus a one-cycle pulse on its falling edge.
module score_sync (
   input  logic clock,
   input  logic reset_L,
   input  logic score_L,
   output logic fire
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = score_L;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign fire = prev_q & ~sync_q;
endmodule

// File: rtl/shot_sequencer.sv
// Turn controller: synchronises the score key, validates the shot and walks the square checker
// over the bomb footprint. Define BATTLESHIP_SHOT_MEMORY_EN to count only first hits per square.
module shot_sequencer
   import battleship_pkg::*;
#(
   parameter int         GRID_MAX  = GRID_MAX_C,
   parameter logic [1:0] BIG_BOMBS = 2'd2,
   parameter int         HIT_W     = 4
) (
   input  logic             clock,
   input  logic             reset_L,
   input  logic             score_L,
   input  coord_t           x,
   input  coord_t           y,
   input  logic             big,
   output coord_t           sq_x,
   output coord_t           sq_y,
   input  logic             sq_hit,
   input  logic             sq_near,
   input  ship_t            sq_ship,
   output logic             hit,
   output logic             near_miss,
   output logic             miss,
   output ship_t            biggest_ship,
   output logic [HIT_W-1:0] num_hits,
   output logic [1:0]       big_left,
   output logic             wrong,
   output logic             busy,
   output logic             done,
   output seq_state_t       dbg_state
);
   // busy spans CHECK..REPORT; done pulses one cycle as the registered results change.
   // A key press that arrives while busy is dropped, never queued.
   seq_state_t       state_q, state_d;
   coord_t           cx_q, cx_d, cy_q, cy_d, sq_x_q, sq_x_d, sq_y_q, sq_y_d;
   logic             big_q, big_d, bad_q, bad_d;
   logic [3:0]       idx_q, idx_d, hit_cnt_q, hit_cnt_d;
   logic             any_hit_q, any_hit_d, any_near_q, any_near_d;
   ship_t            ship_acc_q, ship_acc_d, ship_q, ship_d;
   logic             hit_q, hit_d, near_q, near_d, miss_q, miss_d, wrong_q, wrong_d, done_q, done_d;
   logic [HIT_W-1:0] num_hits_q, num_hits_d;
   logic [1:0]       big_left_q, big_left_d;

   logic             fire, wrong_now, seen;
   logic [3:0]       first_idx, nxt_idx;
   logic [HIT_W:0]   hit_sum;

`ifdef BATTLESHIP_SHOT_MEMORY_EN
   localparam int MAP_N  = GRID_MAX * GRID_MAX;
   localparam int MAP_AW = $clog2(MAP_N);
   logic [MAP_N-1:0] map_q, map_d;

   function automatic logic [MAP_AW-1:0] map_addr(input coord_t px, input coord_t py);
      return MAP_AW'((int'(py) - 1) * GRID_MAX + int'(px) - 1);
   endfunction
`endif

   score_sync u_sync (
      .clock   (clock),
      .reset_L (reset_L),
      .score_L (score_L),
      .fire    (fire)
   );

   always_comb begin
      wrong_now = !in_grid({1'b0, x}, GRID_MAX) || !in_grid({1'b0, y}, GRID_MAX) ||
                  (big && big_left_q == 2'd0);
      first_idx = next_probe(x, y, big, 4'd0, GRID_MAX);
      nxt_idx   = next_probe(cx_q, cy_q, big_q, idx_q + 4'd1, GRID_MAX);
`ifdef BATTLESHIP_SHOT_MEMORY_EN
      seen      = map_q[map_addr(sq_x_q, sq_y_q)];
      map_d     = map_q;
`else
      seen      = 1'b0;
`endif
      hit_sum    = {1'b0, num_hits_q} + {{(HIT_W-3){1'b0}}, hit_cnt_q};
      state_d    = state_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      big_d      = big_q;
      bad_d      = bad_q;
      idx_d      = idx_q;
      sq_x_d     = sq_x_q;
      sq_y_d     = sq_y_q;
      any_hit_d  = any_hit_q;
      any_near_d = any_near_q;
      ship_acc_d = ship_acc_q;
      hit_cnt_d  = hit_cnt_q;
      hit_d      = hit_q;
      near_d     = near_q;
      miss_d     = miss_q;
      ship_d     = ship_q;
      wrong_d    = wrong_q;
      num_hits_d = num_hits_q;
      big_left_d = big_left_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: if (fire) state_d = CHECK;
         CHECK: begin
            cx_d       = x;
            cy_d       = y;
            big_d      = big;
            bad_d      = wrong_now;
            any_hit_d  = 1'b0;
            any_near_d = 1'b0;
            ship_acc_d = '0;
            hit_cnt_d  = '0;
            if (wrong_now) begin
               state_d = REPORT;
            end else begin
               state_d = SCAN;
               idx_d   = first_idx;
               sq_x_d  = coord_t'(offset_coord(x, idx_dx(first_idx)));
               sq_y_d  = coord_t'(offset_coord(y, idx_dy(first_idx)));
            end
         end
         SCAN: begin
            any_hit_d  = any_hit_q | sq_hit;
            any_near_d = any_near_q | sq_near;
            ship_acc_d = ship_acc_q | sq_ship;
            hit_cnt_d  = hit_cnt_q + {3'b000, sq_hit & ~seen};
            if (nxt_idx == NO_PROBE) begin
               state_d = REPORT;
            end else begin
               idx_d  = nxt_idx;
               sq_x_d = coord_t'(offset_coord(cx_q, idx_dx(nxt_idx)));
               sq_y_d = coord_t'(offset_coord(cy_q, idx_dy(nxt_idx)));
            end
         end
         REPORT: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (bad_q) begin
               wrong_d = 1'b1;
               hit_d   = 1'b0;
               near_d  = 1'b0;
               miss_d  = 1'b0;
               ship_d  = '0;
            end else begin
               wrong_d    = 1'b0;
               hit_d      = any_hit_q;
               near_d     = ~any_hit_q & any_near_q;
               miss_d     = ~any_hit_q & ~any_near_q;
               ship_d     = ship_acc_q;
               num_hits_d = hit_sum[HIT_W] ? '1 : hit_sum[HIT_W-1:0];
               big_left_d = big_left_q - {1'b0, big_q};
`ifdef BATTLESHIP_SHOT_MEMORY_EN
               for (int k = 0; k < 9; k++) begin
                  if (probe_ok(cx_q, cy_q, big_q, 4'(k), GRID_MAX))
                     map_d[map_addr(coord_t'(offset_coord(cx_q, idx_dx(4'(k)))),
                                    coord_t'(offset_coord(cy_q, idx_dy(4'(k)))))] = 1'b1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= IDLE;
         cx_q       <= '0;
         cy_q       <= '0;
         big_q      <= 1'b0;
         bad_q      <= 1'b0;
         idx_q      <= '0;
         sq_x_q     <= '0;
         sq_y_q     <= '0;
         any_hit_q  <= 1'b0;
         any_near_q <= 1'b0;
         ship_acc_q <= '0;
         hit_cnt_q  <= '0;
         hit_q      <= 1'b0;
         near_q     <= 1'b0;
         miss_q     <= 1'b0;
         ship_q     <= '0;
         wrong_q    <= 1'b0;
         num_hits_q <= '0;
         big_left_q <= BIG_BOMBS;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         big_q      <= big_d;
         bad_q      <= bad_d;
         idx_q      <= idx_d;
         sq_x_q     <= sq_x_d;
         sq_y_q     <= sq_y_d;
         any_hit_q  <= any_hit_d;
         any_near_q <= any_near_d;
         ship_acc_q <= ship_acc_d;
         hit_cnt_q  <= hit_cnt_d;
         hit_q      <= hit_d;
         near_q     <= near_d;
         miss_q     <= miss_d;
         ship_q     <= ship_d;
         wrong_q    <= wrong_d;
         num_hits_q <= num_hits_d;
         big_left_q <= big_left_d;
         done_q     <= done_d;
      end
   end

`ifdef BATTLESHIP_SHOT_MEMORY_EN
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) map_q <= '0;
      else          map_q <= map_d;
   end
`endif

   assign sq_x         = sq_x_q;
   assign sq_y         = sq_y_q;
   assign hit          = hit_q;
   assign near_miss    = near_q;
   assign miss         = miss_q;
   assign biggest_ship = ship_q;
   assign num_hits     = num_hits_q;
   assign big_left     = big_left_q;
   assign wrong        = wrong_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign dbg_state    = state_q;
endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer: fixed ship layout as the square checker,
// table-driven shots plus hand sequences for busy re-press, reset mid-scan and edge blocks.
module tb_shot_sequencer;
   import battleship_pkg::*;

   localparam int W = 19;
`ifdef BATTLESHIP_SHOT_MEMORY_EN
   localparam bit MEM_EN = 1'b1;
`else
   localparam bit MEM_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_L, score_L, big;
   coord_t     x, y, sq_x, sq_y;
   logic       sq_hit, sq_near;
   ship_t      sq_ship, biggest_ship;
   logic       hit, near_miss, miss, wrong, busy, done;
   logic [3:0] num_hits;
   logic [1:0] big_left;
   seq_state_t dbg_state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   int   probe_cnt = 0;
   logic bad_sq = 1'b0;

   logic [3:0] m_num_hits;
   logic [1:0] m_big_left;
   bit         m_map [0:15][0:15];

   typedef struct {
      coord_t     tx;
      coord_t     ty;
      logic       tb;
      logic [8:0] flags;   // {wrong, hit, near_miss, miss, biggest_ship}
      logic [3:0] probes;
   } vec_t;
   vec_t tab [17];

   shot_sequencer dut (
      .clock        (clock),
      .reset_L      (reset_L),
      .score_L      (score_L),
      .x            (x),
      .y            (y),
      .big          (big),
      .sq_x         (sq_x),
      .sq_y         (sq_y),
      .sq_hit       (sq_hit),
      .sq_near      (sq_near),
      .sq_ship      (sq_ship),
      .hit          (hit),
      .near_miss    (near_miss),
      .miss         (miss),
      .biggest_ship (biggest_ship),
      .num_hits     (num_hits),
      .big_left     (big_left),
      .wrong        (wrong),
      .busy         (busy),
      .done         (done),
      .dbg_state    (dbg_state)
   );

   always #5 clock = ~clock;

   // ---------------- square checker model ----------------
   function automatic ship_t ship_at(input int px, input int py);
      ship_t s;
      s = '0;
      if (py == 6 && (px == 7 || px == 8))  s = 5'b00001;
      if (py == 1 && (px == 9 || px == 10)) s = 5'b00001;
      if (px == 2 && py >= 8 && py <= 10)   s = 5'b00010;
      if (py == 1 && px >= 2 && px <= 4)    s = 5'b00100;
      if (py == 2 && px >= 1 && px <= 4)    s = 5'b01000;
      if (py == 3 && px >= 2 && px <= 6)    s = 5'b10000;
      return s;
   endfunction

   function automatic logic near_at(input int px, input int py);
      logic n;
      n = 1'b0;
      if (ship_at(px, py) == 5'b0) begin
         for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
               if (ship_at(px + dx, py + dy) != 5'b0) n = 1'b1;
      end
      return n;
   endfunction

   always_comb begin
      sq_ship = ship_at(int'(sq_x), int'(sq_y));
      sq_hit  = |sq_ship;
      sq_near = near_at(int'(sq_x), int'(sq_y));
   end

   always @(negedge clock) begin
      if (reset_L && dbg_state == SCAN) begin
         probe_cnt = probe_cnt + 1;
         if (sq_x == 4'd0 || sq_x > 4'd10 || sq_y == 4'd0 || sq_y > 4'd10) bad_sq = 1'b1;
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_num_hits = '0;
      m_big_left = 2'd2;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) m_map[i][j] = 1'b0;
   endtask

   task automatic model_shot(input int sx, input int sy, input logic sb,
                             output logic [8:0] flags, output logic [3:0] probes);
      logic  ah, an, bad;
      ship_t sh;
      int    cnt, np, sum;
      ah = 1'b0; an = 1'b0; sh = '0; cnt = 0; np = 0;
      bad = sx < 1 || sx > 10 || sy < 1 || sy > 10 || (sb && m_big_left == 2'd0);
      if (bad) begin
         flags  = 9'b1_0000_0000;
         probes = 4'd0;
      end else begin
         for (int py = sy - 1; py <= sy + 1; py++) begin
            for (int px = sx - 1; px <= sx + 1; px++) begin
               if ((sb || (px == sx && py == sy)) && px >= 1 && px <= 10 && py >= 1 && py <= 10) begin
                  np++;
                  sh |= ship_at(px, py);
                  an |= near_at(px, py);
                  if (ship_at(px, py) != 5'b0) begin
                     ah = 1'b1;
                     if (!(MEM_EN && m_map[px][py])) cnt++;
                  end
                  m_map[px][py] = 1'b1;
               end
            end
         end
         sum        = int'(m_num_hits) + cnt;
         m_num_hits = (sum > 15) ? 4'd15 : 4'(sum);
         m_big_left = m_big_left - {1'b0, sb};
         flags      = {1'b0, ah, ~ah & an, ~ah & ~an, sh};
         probes     = 4'(np);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_hit", hit, 0);
      chk("rst_near", near_miss, 0);
      chk("rst_miss", miss, 0);
      chk("rst_wrong", wrong, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ship", biggest_ship, 0);
      chk("rst_num_hits", num_hits, 0);
      chk("rst_big_left", big_left, 2);
      chk("rst_sq_x", sq_x, 0);
      chk("rst_sq_y", sq_y, 0);
      chk("rst_state_idle", dbg_state == IDLE, 1);
   endtask

   task automatic shoot(input coord_t sx, input coord_t sy, input logic sb, input logic use_tab,
                        input logic [8:0] t_flags, input logic [3:0] t_probes, input logic repress);
      logic [8:0]   flags;
      logic [3:0]   probes;
      logic [W-1:0] e;
      int           lat;
      logic         quiet;
      model_shot(int'(sx), int'(sy), sb, flags, probes);
      if (use_tab) begin
         flags  = t_flags;
         probes = t_probes;
      end
      exp_q.push_back({flags, m_num_hits, m_big_left, probes});

      @(negedge clock);
      x = sx; y = sy; big = sb; score_L = 1'b0;
      probe_cnt = 0; bad_sq = 1'b0; lat = 0;
      while (!done && lat < 60) begin
         @(negedge clock);
         lat++;
         if (lat == 4) begin
            x   = coord_t'($urandom_range(0, 15));
            y   = coord_t'($urandom_range(0, 15));
            big = 1'($urandom_range(0, 1));
         end
         if (repress && lat == 6) score_L = 1'b1;
         if (repress && lat == 7) score_L = 1'b0;
      end
      chk("done_seen", done, 1);
      e = exp_q.pop_front();
      chk("wrong", wrong, e[18]);
      chk("hit", hit, e[17]);
      chk("near_miss", near_miss, e[16]);
      chk("miss", miss, e[15]);
      chk("biggest_ship", biggest_ship, e[14:10]);
      chk("num_hits", num_hits, e[9:6]);
      chk("big_left", big_left, e[5:4]);
      chk("probes", probe_cnt, e[3:0]);
      chk("latency", lat, 5 + int'(e[3:0]));
      chk("sq_in_grid", bad_sq, 0);

      score_L = 1'b1;
      quiet = 1'b1;
      repeat (8) begin
         @(negedge clock);
         if (busy || done) quiet = 1'b0;
      end
      chk("no_refire", quiet, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [8:0] fl;
      logic [3:0] pr;
      int         n;

      tab[0]  = '{4'd7,  4'd6,  1'b0, 9'b0_100_00001, 4'd1};
      tab[1]  = '{4'd7,  4'd7,  1'b0, 9'b0_010_00000, 4'd1};
      tab[2]  = '{4'd5,  4'd5,  1'b0, 9'b0_001_00000, 4'd1};
      tab[3]  = '{4'd3,  4'd2,  1'b1, 9'b0_100_11100, 4'd9};
      tab[4]  = '{4'd1,  4'd1,  1'b1, 9'b0_100_01100, 4'd4};
      tab[5]  = '{4'd0,  4'd5,  1'b0, 9'b1_000_00000, 4'd0};
      tab[6]  = '{4'd5,  4'd11, 1'b0, 9'b1_000_00000, 4'd0};
      tab[7]  = '{4'd3,  4'd0,  1'b0, 9'b1_000_00000, 4'd0};
      tab[8]  = '{4'd5,  4'd5,  1'b1, 9'b1_000_00000, 4'd0};
      tab[9]  = '{4'd8,  4'd6,  1'b0, 9'b0_100_00001, 4'd1};
      tab[10] = '{4'd10, 4'd10, 1'b0, 9'b0_001_00000, 4'd1};
      tab[11] = '{4'd2,  4'd10, 1'b0, 9'b0_100_00010, 4'd1};
      tab[12] = '{4'd9,  4'd1,  1'b0, 9'b0_100_00001, 4'd1};
      tab[13] = '{4'd10, 4'd1,  1'b0, 9'b0_100_00001, 4'd1};
      tab[14] = '{4'd2,  4'd9,  1'b0, 9'b0_100_00010, 4'd1};
      tab[15] = '{4'd6,  4'd3,  1'b0, 9'b0_100_10000, 4'd1};
      tab[16] = '{4'd15, 4'd3,  1'b0, 9'b1_000_00000, 4'd0};

      reset_L = 1'b0; score_L = 1'b1; x = '0; y = '0; big = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      check_reset_vals();
      reset_L = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_vals();

      for (int i = 0; i < 17; i++)
         shoot(tab[i].tx, tab[i].ty, tab[i].tb, 1'b1, tab[i].flags, tab[i].probes, 1'b0);

      // fresh bombs, then a big interior shot with a second press while busy
      @(negedge clock); reset_L = 1'b0;
      @(negedge clock); reset_L = 1'b1;
      model_reset();
      @(negedge clock);
      check_reset_vals();
      shoot(4'd6, 4'd6, 1'b1, 1'b0, 9'b0, 4'd0, 1'b1);

      // asynchronous reset in the middle of a scan
      @(negedge clock);
      x = 4'd5; y = 4'd5; big = 1'b1; score_L = 1'b0;
      n = 0;
      while (dbg_state != SCAN && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("reach_scan", dbg_state == SCAN, 1);
      #1 reset_L = 1'b0;
      #1 check_reset_vals();
      @(negedge clock);
      reset_L = 1'b1; score_L = 1'b1;
      model_reset();
      repeat (3) @(negedge clock);
      check_reset_vals();

      // edge block: 6 probes
      shoot(4'd10, 4'd5, 1'b1, 1'b0, 9'b0, 4'd0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         model_shot(0, 0, 1'b0, fl, pr);  // illegal shot: model state untouched
         shoot(coord_t'($urandom_range(0, 11)), coord_t'($urandom_range(0, 11)),
               1'($urandom_range(0, 1)), 1'b0, 9'b0, 4'd0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
